// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and oversampling/parity constants shared by uart_rx and uart_tx.
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam int OVERSAMPLE = 16;
    localparam int SAMPLE_MID = 7;
    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD = 1'b1;
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: received-byte stream with valid/ready handshake and per-byte error flags.
interface uart_rx_if;
    logic [7:0] data;
    logic valid;
    logic ready;
    logic parity_err;
    logic frame_err;
    logic overrun;
    modport master(output data, valid, parity_err, frame_err, overrun, input ready);
    modport slave(input data, valid, parity_err, frame_err, overrun, output ready);
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: fractional accumulator producing OVERSAMPLE ticks per bit at the given baud rate.
module uart_baud_tick import uart_pkg::*; #(
    parameter int CLK_FREQ = 25_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic [31:0] baud,
    output logic        tick
);
    logic [35:0] acc;
    logic [36:0] sum;
    logic        wrap;
    assign sum = {1'b0, acc} + 37'(baud) * 37'(OVERSAMPLE);
    assign wrap = sum >= 37'(CLK_FREQ);
    // acc stays below CLK_FREQ, so dropping sum[36] after the subtract is lossless
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
            tick <= 1'b0;
        end else if (clear) begin
            acc <= '0;
            tick <= 1'b0;
        end else begin
            tick <= wrap;
            acc <= wrap ? 36'(sum - 37'(CLK_FREQ)) : sum[35:0];
        end
    end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver (8N1 or 8 data + parity) with valid/ready output.
module uart_rx import uart_pkg::*; #(
    parameter int CLK_FREQ = 25_000_000,
    parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    input  logic [31:0] baudrate,
    input  logic        parity_en,
    input  logic        parity_type,
    uart_rx_if.master   out
);
    state_t state, state_n;
    logic [1:0] sync;
    logic rx_s, rx_d, fall, baud_ok, tick, mid, sample, start, cap;
    logic [3:0] tcnt;
    logic [2:0] bidx;
    logic [7:0] data_sh, data;
    logic [31:0] baud_l;
    logic par_en_l, par_type_l, perr;
    logic valid, parity_err, frame_err, overrun;
    assign rx_s = sync[1];
    assign fall = rx_d & ~rx_s;
    assign baud_ok = baudrate != 32'd0 && 36'(baudrate) * 36'(OVERSAMPLE) <= 36'(CLK_FREQ);
    assign mid = tick && tcnt == 4'(SAMPLE_MID);
    assign sample = tick && tcnt == 4'(OVERSAMPLE - 1);
    uart_baud_tick #(.CLK_FREQ(CLK_FREQ)) u_tick (
        .clk(clk),
        .rst(rst),
        .clear(start),
        .baud(baud_l),
        .tick(tick)
    );
    always_comb begin
        state_n = state;
        start = 1'b0;
        cap = 1'b0;
        case (state)
            IDLE: begin
                start = fall && baud_ok;
                state_n = (fall && baud_ok) ? START : IDLE;
            end
            START: state_n = mid ? (rx_s ? IDLE : DATA) : START;
            DATA: state_n = (sample && bidx == 3'd7) ? (par_en_l ? PARITY : STOP) : DATA;
            PARITY: state_n = sample ? STOP : PARITY;
            STOP: begin
                cap = sample;
                state_n = sample ? IDLE : STOP;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            sync <= 2'b11;
            rx_d <= 1'b1;
        end else begin
            state <= state_n;
            sync <= {sync[0], rx};
            rx_d <= rx_s;
        end
    end
    // returning to IDLE at mid-stop leaves half a bit to catch the next start edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt <= '0;
            bidx <= '0;
            data_sh <= '0;
            baud_l <= '0;
            par_en_l <= 1'b0;
            par_type_l <= 1'b0;
            perr <= 1'b0;
            data <= '0;
            valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (start) begin
                baud_l <= baudrate;
                par_en_l <= parity_en;
                par_type_l <= parity_type;
                perr <= 1'b0;
                bidx <= '0;
            end
            tcnt <= (start || (state == START && mid)) ? '0 : (state != IDLE && tick) ? tcnt + 4'd1 : tcnt;
            if (state == DATA && sample) begin
                data_sh <= {rx_s, data_sh[7:1]};
                bidx <= bidx + 3'd1;
            end
            if (state == PARITY && sample) perr <= (^data_sh ^ rx_s) != par_type_l;
            overrun <= cap && valid;
            if (valid && out.ready) valid <= 1'b0;
            else if (cap && !valid) begin
                data <= data_sh;
                parity_err <= perr;
                frame_err <= !rx_s;
                valid <= 1'b1;
            end
        end
    end
    assign out.data = data;
    assign out.valid = valid;
    assign out.parity_err = parity_err;
    assign out.frame_err = frame_err;
    assign out.overrun = overrun;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed frames against a queue-based scoreboard of expected bytes.
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int CLK_FREQ = 25_000_000;
    typedef struct packed {
        logic [7:0] d;
        logic pe;
        logic fe;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx = 1'b1;
    logic [31:0] baudrate = 32'd115200;
    logic parity_en = 1'b0;
    logic parity_type = 1'b0;
    int checks = 0;
    int passed = 0;
    int ov_seen = 0;
    int cyc = 0;
    logic valid_q = 1'b0;
    exp_t q[$];
    exp_t e;
    uart_rx_if bus();
    uart_rx #(.CLK_FREQ(CLK_FREQ)) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .baudrate(baudrate),
        .parity_en(parity_en),
        .parity_type(parity_type),
        .out(bus)
    );
    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask
    // scoreboard monitor: every new byte presented is matched against the oldest expectation
    always @(negedge clk) begin
        if (bus.overrun === 1'b1) ov_seen++;
        if (bus.valid === 1'b1 && !valid_q) begin
            if (q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_byte: got %02h, expected none", bus.data);
            end else begin
                e = q.pop_front();
                check("data", {24'd0, bus.data}, {24'd0, e.d});
                check("parity_err", {31'd0, bus.parity_err}, {31'd0, e.pe});
                check("frame_err", {31'd0, bus.frame_err}, {31'd0, e.fe});
            end
        end
        valid_q = bus.valid;
    end
    function automatic int bit_clks(input int baud);
        return (CLK_FREQ + baud / 2) / baud;
    endfunction
    // reference: odd parity is correct when data+parity holds an odd number of ones
    task automatic expect_byte(input logic [7:0] b, input logic pen, input logic ptype, input logic pbit, input logic stop);
        exp_t x;
        int ones;
        ones = $countones(b) + int'(pbit);
        x.d = b;
        x.pe = pen && ((ones % 2 == 1) != ptype);
        x.fe = !stop;
        q.push_back(x);
    endtask
    task automatic send(input logic [7:0] b, input logic pen, input logic pbit, input logic stop, input int bc, input int gap);
        rx = 1'b0;
        repeat (bc) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (bc) @(negedge clk);
        end
        if (pen) begin
            rx = pbit;
            repeat (bc) @(negedge clk);
        end
        rx = stop;
        repeat (bc) @(negedge clk);
        rx = 1'b1;
        repeat (gap * bc) @(negedge clk);
    endtask
    task automatic wait_valid(input int budget, input string name);
        int n;
        n = 0;
        while (bus.valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, bus.valid}, 32'd1);
    endtask
    task automatic drain(input int budget, input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, q.size(), 0);
    endtask
    initial begin
        int bc, t0, lat, ov0;
        logic [7:0] b;
        logic pen, ptype, pbit, stop;
        bus.ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data", {24'd0, bus.data}, 32'd0);
        check("rst_valid", {31'd0, bus.valid}, 32'd0);
        check("rst_perr", {31'd0, bus.parity_err}, 32'd0);
        check("rst_ferr", {31'd0, bus.frame_err}, 32'd0);
        check("rst_overrun", {31'd0, bus.overrun}, 32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        // basic 8N1 byte, latency and consume
        bc = bit_clks(115200);
        expect_byte(8'h41, 1'b0, 1'b0, 1'b0, 1'b1);
        t0 = cyc;
        lat = 0;
        fork
            send(8'h41, 1'b0, 1'b0, 1'b1, bc, 2);
            begin
                wait_valid(12 * bc, "t1_valid");
                lat = cyc - t0;
            end
        join
        checks++;
        if (lat >= 9 * bc && lat <= 10 * bc) passed++;
        else $display("FAIL t1_latency: got %0d clk, expected %0d..%0d", lat, 9 * bc, 10 * bc);
        bus.ready = 1'b1;
        @(negedge clk);
        bus.ready = 1'b0;
        check("t1_consumed", {31'd0, bus.valid}, 32'd0);
        check("t1_data_held", {24'd0, bus.data}, 32'h41);
        bus.ready = 1'b1;
        // odd parity, correct and wrong parity bit
        parity_en = 1'b1;
        parity_type = 1'b1;
        expect_byte(8'h41, 1'b1, 1'b1, 1'b1, 1'b1);
        send(8'h41, 1'b1, 1'b1, 1'b1, bc, 2);
        expect_byte(8'h41, 1'b1, 1'b1, 1'b0, 1'b1);
        send(8'h41, 1'b1, 1'b0, 1'b1, bc, 2);
        drain(4 * bc, "t2_drain");
        // framing error, then break
        parity_en = 1'b0;
        expect_byte(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'h55, 1'b0, 1'b0, 1'b0, bc, 2);
        expect_byte(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (20 * bc) @(negedge clk);
        rx = 1'b1;
        repeat (3 * bc) @(negedge clk);
        drain(4 * bc, "t3_drain");
        // short low glitch must be rejected, following frame still received
        rx = 1'b0;
        repeat (3 * bc / 16) @(negedge clk);
        rx = 1'b1;
        repeat (2 * bc) @(negedge clk);
        expect_byte(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
        send(8'hA5, 1'b0, 1'b0, 1'b1, bc, 2);
        drain(4 * bc, "t4_drain");
        // back-to-back frames with consumer stalled: second one overruns
        bus.ready = 1'b0;
        ov0 = ov_seen;
        expect_byte(8'h12, 1'b0, 1'b0, 1'b0, 1'b1);
        send(8'h12, 1'b0, 1'b0, 1'b1, bc, 0);
        send(8'h34, 1'b0, 1'b0, 1'b1, bc, 2);
        check("t5_overrun_cycles", ov_seen - ov0, 1);
        check("t5_data_kept", {24'd0, bus.data}, 32'h12);
        check("t5_valid_kept", {31'd0, bus.valid}, 32'd1);
        bus.ready = 1'b1;
        @(negedge clk);
        check("t5_consumed", {31'd0, bus.valid}, 32'd0);
        // asynchronous reset mid-frame, then a slow clean frame
        fork
            send(8'hFF, 1'b0, 1'b0, 1'b1, bc, 2);
            begin
                repeat (4 * bc) @(negedge clk);
                rst = 1'b0;
                #1;
                check("t6_rst_data", {24'd0, bus.data}, 32'd0);
                check("t6_rst_valid", {31'd0, bus.valid}, 32'd0);
                check("t6_rst_ferr", {31'd0, bus.frame_err}, 32'd0);
                repeat (3) @(negedge clk);
                rst = 1'b1;
            end
        join
        baudrate = 32'd9600;
        bc = bit_clks(9600);
        expect_byte(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
        send(8'h3C, 1'b0, 1'b0, 1'b1, bc, 1);
        drain(4 * bc, "t6_drain");
        // randomized frames checked against the reference model
        for (int i = 0; i < 10; i++) begin
            baudrate = $urandom_range(0, 1) ? 32'd230400 : 32'd460800;
            bc = bit_clks(int'(baudrate));
            b = 8'($urandom);
            pen = 1'($urandom_range(0, 1));
            ptype = 1'($urandom_range(0, 1));
            pbit = 1'($urandom_range(0, 1));
            stop = $urandom_range(0, 7) != 0;
            parity_en = pen;
            parity_type = ptype;
            expect_byte(b, pen, ptype, pbit, stop);
            send(b, pen, pbit, stop, bc, 2);
        end
        drain(20 * bc, "rand_drain");
        check("total_overruns", ov_seen, 1);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
